// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// One radix-2 step per cycle over a 64-bit accumulator, then a sign-fix cycle.
`timescale 1ns/1ps
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic             cancel,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    ONE_DW   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = ~v + ONE_W;
        end else begin
            magnitude = v;
        end
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            apply_sign_w = ~v + ONE_W;
        end else begin
            apply_sign_w = v;
        end
    endfunction

    function automatic logic [DW-1:0] apply_sign_dw(input logic [DW-1:0] v, input logic neg);
        if (neg) begin
            apply_sign_dw = ~v + ONE_DW;
        end else begin
            apply_sign_dw = v;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    acc_r;
    logic [WIDTH-1:0] opnd_r;
    logic             is_div_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             ready_r;

    logic             accept_s;
    logic             signed_op_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   mul_addend_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_diff_s;
    logic [DW-1:0]    acc_next_s;
    logic [DW-1:0]    prod_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    assign ready = ready_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

    // Issue decode: ready_r is only high in IDLE, so it gates acceptance.
    always_comb begin
        accept_s    = start && !cancel && ready_r;
        signed_op_s = ~op[0];
        a_mag_s     = magnitude(src0, signed_op_s);
        b_mag_s     = magnitude(src1, signed_op_s);
    end

    // One iteration: multiply keeps {partial, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_addend_s = acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}};
        mul_sum_s    = {1'b0, acc_r[DW-1:WIDTH]} + mul_addend_s;
        div_diff_s   = acc_r[DW-1:WIDTH-1] - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[DW-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction; a zero divisor leaves |src0| as remainder, which re-signs back to src0.
    always_comb begin
        prod_s = apply_sign_dw(acc_r, neg_q_r);
        rem_s  = apply_sign_w(acc_r[DW-1:WIDTH], neg_rem_r);
        if (div_zero_r) begin
            quot_s = {WIDTH{1'b1}};
        end else begin
            quot_s = apply_sign_w(acc_r[WIDTH-1:0], neg_q_r);
        end
        if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quot_s;
        end else begin
            fix_hi_s = prod_s[DW-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, operand latching, iteration and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {DW{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (!op[2]) begin
                            is_div_r   <= op[1];
                            opnd_r     <= op[1] ? b_mag_s : a_mag_s;
                            acc_r      <= {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
                            neg_q_r    <= signed_op_s & (src0[WIDTH-1] ^ src1[WIDTH-1]);
                            neg_rem_r  <= signed_op_s & src0[WIDTH-1];
                            div_zero_r <= (src1 == {WIDTH{1'b0}});
                            cnt_r      <= {CNT_W{1'b0}};
                            ready_r    <= 1'b0;
                            state_r    <= CALC;
                        end else if (op == 3'd4) begin
                            hi_r <= src0;
                        end else if (op == 3'd5) begin
                            lo_r <= src0;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + ONE_CNT;
                        if (cnt_r == LAST_CNT) begin
                            state_r <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        hi_r   <= fix_hi_s;
                        lo_r   <= fix_lo_s;
                        done_r <= 1'b1;
                    end
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: stimulus pushes reference results,
// a negedge monitor pops and compares whenever done pulses.
`timescale 1ns/1ps
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        cancel;
    logic        ready;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src0(src0), .src1(src1),
        .cancel(cancel), .ready(ready), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f_op)
            3'd0: ref_model = sa * sb;
            3'd1: begin
                u = {32'd0, a} * {32'd0, b};
                ref_model = u;
            end
            3'd2: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_model = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFFFFFF};
                else ref_model = {a % b, a / b};
            end
            default: ref_model = {m_hi, m_lo};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = exp_q.pop_front();
                check("result_hi", hi, e[63:32]);
                check("result_lo", lo, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b, input bit intrude);
        int low;
        logic [63:0] e;
        start = 1'b1; op = f_op; src0 = a; src1 = b;
        @(posedge clk); #1;
        start = 1'b0;
        e = ref_model(f_op, a, b);
        exp_q.push_back(e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(negedge clk);
        low = 0;
        while (ready !== 1'b1 && low < 40) begin
            low++;
            if (intrude && low == 5) begin
                start = 1'b1; op = 3'd5; src0 = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", low, 32'd33);
    endtask

    task automatic do_cancel(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b, input int cyc);
        start = 1'b1; op = f_op; src0 = a; src1 = b;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (cyc) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_ready", {31'd0, ready}, 32'd1);
        repeat (40) @(negedge clk);
        check("cancel_hi_hold", hi, m_hi);
        check("cancel_lo_hold", lo, m_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; src0 = 32'd0; src1 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        do_op(3'd1, 32'hFFFFFFFF, 32'h23, 1'b0);
        check("multu_hi", hi, 32'h00000022);
        check("multu_lo", lo, 32'hFFFFFFDD);
        do_op(3'd0, 32'hFFFFFFFF, 32'h23, 1'b0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFDD);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_lo", lo, 32'hFFFFFFFD);
        do_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_hi", hi, 32'd1);
        check("divu_lo", lo, 32'd3);
        do_op(3'd2, 32'h1234, 32'd0, 1'b0);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'hFFFFFFFF);
        do_op(3'd2, 32'hFFFFFF00, 32'd0, 1'b0);
        check("div0_neg_hi", hi, 32'hFFFFFF00);
        check("div0_neg_lo", lo, 32'hFFFFFFFF);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divovf_hi", hi, 32'd0);
        check("divovf_lo", lo, 32'h80000000);

        // MTHI in IDLE lands on the accepting edge with no done.
        @(negedge clk);
        start = 1'b1; op = 3'd4; src0 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        start = 1'b0;
        m_hi = 32'hA5A5A5A5;
        check("mthi_hi", hi, 32'hA5A5A5A5);
        check("mthi_ready", {31'd0, ready}, 32'd1);
        check("mthi_done", {31'd0, done}, 32'd0);
        // cancel beats start in IDLE, even for MTLO.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd5; src0 = 32'h11111111;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_mtlo_lo", lo, m_lo);
        check("cancel_start_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);

        do_op(3'd1, 32'h00010000, 32'h00000300, 1'b1);
        check("busy_mtlo_lo", lo, 32'h03000000);

        @(negedge clk);
        do_cancel(3'd3, 32'd1000, 32'd7, 9);

        // Reset in the middle of CALC wipes HI/LO.
        @(negedge clk);
        start = 1'b1; op = 3'd0; src0 = 32'h1234; src1 = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_done", {31'd0, done}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 15));
                2: r_a = 32'h80000000;
                3: r_b = 32'hFFFFFFFF;
                default: r_b = r_b;
            endcase
            do_op(r_op, r_a, r_b, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_hi", hi, m_hi);
        check("final_lo", lo, m_lo);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
